// File: rtl/x1_ioctl_upload.sv
// x1_ioctl_upload: answers framework ioctl upload (save) byte reads by fetching
// each byte from a core-side memory port that has a variable ack latency.
// Reads beyond the image size return 8'hFF without touching memory.
module x1_ioctl_upload #(
    parameter logic [7:0]  INDEX   = 8'h01,
    parameter logic [24:0] SIZE    = 25'h010000,
    parameter int          TIMEOUT = 255
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic [24:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_din,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FETCH     = 2'd1,
        S_DONE_WAIT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic [7:0]    r_din,   w_din_n;
    logic          r_wait,  w_wait_n;
    logic [24:0]   r_addr,  w_addr_n;
    logic          r_rd,    w_rd_n;
    logic [CW-1:0] r_cnt,   w_cnt_n;
    logic          r_err,   w_err_n;
    logic          r_busy;
    logic          r_done;

    logic w_sel;
    logic w_timeout;

    assign w_sel     = ioctl_upload & (ioctl_index == INDEX);
    assign w_timeout = (r_cnt == TMO);

    // Next-state and next-output decode; every register holds unless told otherwise.
    always_comb begin
        w_state_n = r_state;
        w_din_n   = r_din;
        w_wait_n  = r_wait;
        w_addr_n  = r_addr;
        w_rd_n    = r_rd;
        w_cnt_n   = r_cnt;
        w_err_n   = r_err;

        // A new selected session starts with a clean error flag; a timeout
        // in the same cycle still wins because it is applied below.
        if (w_sel && !r_busy) begin
            w_err_n = 1'b0;
        end else begin
            w_err_n = r_err;
        end

        case (r_state)
            S_IDLE: begin
                w_wait_n = 1'b0;
                w_rd_n   = 1'b0;
                w_cnt_n  = '0;
                if (ioctl_rd && w_sel) begin
                    w_addr_n = ioctl_addr;
                    if (ioctl_addr < SIZE) begin
                        w_state_n = S_FETCH;
                        w_rd_n    = 1'b1;
                        w_wait_n  = 1'b1;
                    end else begin
                        w_din_n = 8'hFF;
                    end
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    // Data is only delivered if the session is still alive.
                    if (w_sel) begin
                        w_din_n = mem_din;
                    end else begin
                        w_din_n = r_din;
                    end
                    w_rd_n    = 1'b0;
                    w_wait_n  = 1'b0;
                    w_state_n = S_IDLE;
                end else if (w_timeout) begin
                    if (w_sel) begin
                        w_din_n = 8'hFF;
                    end else begin
                        w_din_n = r_din;
                    end
                    w_err_n   = 1'b1;
                    w_rd_n    = 1'b0;
                    w_wait_n  = 1'b0;
                    w_state_n = S_IDLE;
                end else if (!w_sel) begin
                    // Session aborted: release the framework now, but keep the
                    // memory handshake open until it completes or times out.
                    w_wait_n  = 1'b0;
                    w_cnt_n   = r_cnt + CW'(1);
                    w_state_n = S_DONE_WAIT;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            S_DONE_WAIT: begin
                w_wait_n = 1'b0;
                if (mem_ack) begin
                    w_rd_n    = 1'b0;
                    w_state_n = S_IDLE;
                end else if (w_timeout) begin
                    w_err_n   = 1'b1;
                    w_rd_n    = 1'b0;
                    w_state_n = S_IDLE;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_rd_n    = 1'b0;
                w_wait_n  = 1'b0;
                w_cnt_n   = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_din   <= 8'h00;
            r_wait  <= 1'b0;
            r_addr  <= 25'd0;
            r_rd    <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_din   <= w_din_n;
            r_wait  <= w_wait_n;
            r_addr  <= w_addr_n;
            r_rd    <= w_rd_n;
            r_cnt   <= w_cnt_n;
            r_err   <= w_err_n;
        end
    end

    // Session tracking: busy is sel delayed one cycle, done marks its falling edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_sel;
            r_done <= ~w_sel & r_busy;
        end
    end

    assign ioctl_din  = r_din;
    assign ioctl_wait = r_wait;
    assign mem_addr   = r_addr;
    assign mem_rd     = r_rd;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_x1_ioctl_upload.sv
// Directed bench for x1_ioctl_upload with a queue of expected returned bytes.
module tb_x1_ioctl_upload;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [24:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [7:0]  mem_din;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_din;

    x1_ioctl_upload #(
        .INDEX   (8'h01),
        .SIZE    (25'h010000),
        .TIMEOUT (8)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_ack      (mem_ack),
        .mem_din      (mem_din),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // In-range read; memory acks after 'lat' FETCH cycles (lat>=1) with 'data'.
    task automatic do_read(input logic [24:0] a, input int lat, input logic [7:0] data);
        logic [7:0] e;
        exp_q.push_back(data);
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        step();
        ioctl_rd = 1'b0;
        check("rd_mem_rd", {31'd0, mem_rd}, 32'd1);
        check("rd_mem_addr", {7'd0, mem_addr}, {7'd0, a});
        for (int i = 1; i < lat; i++) begin
            check("rd_wait_hi", {31'd0, ioctl_wait}, 32'd1);
            step();
        end
        check("rd_wait_hi_last", {31'd0, ioctl_wait}, 32'd1);
        mem_ack = 1'b1;
        mem_din = data;
        step();
        mem_ack = 1'b0;
        mem_din = 8'h00;
        e = exp_q.pop_front();
        last_din = e;
        check("rd_wait_lo", {31'd0, ioctl_wait}, 32'd0);
        check("rd_mem_rd_lo", {31'd0, mem_rd}, 32'd0);
        check("rd_din", {24'd0, ioctl_din}, {24'd0, e});
    endtask

    initial begin
        reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'h00; ioctl_rd = 1'b0;
        ioctl_addr = 25'd0; mem_ack = 1'b0; mem_din = 8'h00; last_din = 8'h00;
        step(); step();
        check("rst_din",  {24'd0, ioctl_din}, 32'h00);
        check("rst_wait", {31'd0, ioctl_wait}, 32'd0);
        check("rst_addr", {7'd0, mem_addr}, 32'd0);
        check("rst_rd",   {31'd0, mem_rd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err",  {31'd0, err}, 32'd0);
        reset = 1'b0;

        // Basic fetch with 3 cycles of wait.
        ioctl_upload = 1'b1; ioctl_index = 8'h01;
        step();
        check("busy_on", {31'd0, busy}, 32'd1);
        do_read(25'h0010, 3, 8'hA5);
        check("err_after_ok", {31'd0, err}, 32'd0);

        // Out of range (== SIZE).
        exp_q.push_back(8'hFF);
        ioctl_rd = 1'b1; ioctl_addr = 25'h10000;
        step();
        ioctl_rd = 1'b0;
        last_din = exp_q.pop_front();
        check("oor_din",  {24'd0, ioctl_din}, {24'd0, last_din});
        check("oor_wait", {31'd0, ioctl_wait}, 32'd0);
        check("oor_rd",   {31'd0, mem_rd}, 32'd0);
        // Stray ack while idle must be ignored.
        mem_ack = 1'b1; mem_din = 8'h77;
        step();
        mem_ack = 1'b0; mem_din = 8'h00;
        check("oor_rd2",     {31'd0, mem_rd}, 32'd0);
        check("stray_ack",   {24'd0, ioctl_din}, {24'd0, last_din});

        // Timeout: 9 FETCH cycles with wait high, then FF and err.
        ioctl_rd = 1'b1; ioctl_addr = 25'h0020;
        step();
        ioctl_rd = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("tmo_wait_hi", {31'd0, ioctl_wait}, 32'd1);
            check("tmo_rd_hi",   {31'd0, mem_rd}, 32'd1);
            step();
        end
        last_din = 8'hFF;
        check("tmo_wait_lo", {31'd0, ioctl_wait}, 32'd0);
        check("tmo_din",     {24'd0, ioctl_din}, 32'hFF);
        check("tmo_err",     {31'd0, err}, 32'd1);
        check("tmo_rd_lo",   {31'd0, mem_rd}, 32'd0);
        ioctl_upload = 1'b0;
        step();
        check("end1_done", {31'd0, done}, 32'd1);
        check("end1_busy", {31'd0, busy}, 32'd0);
        step();
        check("end1_done_off", {31'd0, done}, 32'd0);
        check("err_sticky",    {31'd0, err}, 32'd1);
        ioctl_upload = 1'b1;
        step();
        check("err_cleared", {31'd0, err}, 32'd0);
        check("busy_on2",    {31'd0, busy}, 32'd1);
        ioctl_upload = 1'b0;
        step(); step();

        // Foreign index: nothing happens.
        ioctl_upload = 1'b1; ioctl_index = 8'h02; ioctl_rd = 1'b1; ioctl_addr = 25'h0005;
        step();
        ioctl_rd = 1'b0;
        check("idx2_rd",   {31'd0, mem_rd}, 32'd0);
        check("idx2_wait", {31'd0, ioctl_wait}, 32'd0);
        check("idx2_busy", {31'd0, busy}, 32'd0);
        ioctl_upload = 1'b0;
        step();
        check("idx2_done", {31'd0, done}, 32'd0);
        step();
        check("idx2_done2", {31'd0, done}, 32'd0);

        // Abort during FETCH.
        ioctl_upload = 1'b1; ioctl_index = 8'h01;
        step();
        ioctl_rd = 1'b1; ioctl_addr = 25'h0040;
        step();
        ioctl_rd = 1'b0;
        check("ab_rd", {31'd0, mem_rd}, 32'd1);
        ioctl_upload = 1'b0;
        step();
        check("ab_wait", {31'd0, ioctl_wait}, 32'd0);
        check("ab_rd_held", {31'd0, mem_rd}, 32'd1);
        check("ab_done", {31'd0, done}, 32'd1);
        step();
        check("ab_rd_held2", {31'd0, mem_rd}, 32'd1);
        check("ab_done_off", {31'd0, done}, 32'd0);
        mem_ack = 1'b1; mem_din = 8'h3C;
        step();
        mem_ack = 1'b0; mem_din = 8'h00;
        check("ab_rd_lo", {31'd0, mem_rd}, 32'd0);
        check("ab_din",   {24'd0, ioctl_din}, {24'd0, last_din});
        check("ab_err",   {31'd0, err}, 32'd0);

        // Reset during FETCH drops mem_rd.
        ioctl_upload = 1'b1;
        step();
        ioctl_rd = 1'b1; ioctl_addr = 25'h0050;
        step();
        ioctl_rd = 1'b0;
        check("rf_rd", {31'd0, mem_rd}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        last_din = 8'h00;
        check("rf_rd_lo",  {31'd0, mem_rd}, 32'd0);
        check("rf_wait",   {31'd0, ioctl_wait}, 32'd0);
        check("rf_din",    {24'd0, ioctl_din}, 32'h00);
        step();

        // 256 back-to-back reads with immediate ack.
        for (int a = 0; a < 256; a++) begin
            logic [24:0] ad;
            ad = 25'(a);
            do_read(ad, 1, ad[7:0]);
        end
        check("b2b_q_empty", exp_q.size(), 32'd0);
        ioctl_upload = 1'b0;
        step();
        check("b2b_done", {31'd0, done}, 32'd1);
        step();
        check("b2b_done_off", {31'd0, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/x1_ioctl_upload.md
# x1_ioctl_upload

Responder for the HPS ioctl upload (save) direction: services per-byte read requests from the framework and returns bytes fetched from a core-side memory port with variable latency. Sits between the framework's ioctl bus and the X1 save-image memory (tape/disk buffer), alongside the existing download path. It is the reverse of the download path: the framework reads, the core supplies data.

## Interface
Parameters:
- INDEX, 8'h01, ioctl_index value this block answers to
- SIZE, 25'h010000, image size in bytes; addresses >= SIZE return 8'hFF without a memory access
- TIMEOUT, 255, maximum cycles waiting for mem_ack before abandoning a fetch

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ioctl_upload  in  1  upload session active
- ioctl_index  in  8  image selector
- ioctl_rd  in  1  one-cycle read request for byte at ioctl_addr
- ioctl_addr  in  25  byte address, sampled with ioctl_rd
- ioctl_din  out  8  returned byte; valid while ioctl_wait low after a request
- ioctl_wait  out  1  high while a fetch is outstanding
- mem_addr  out  25  memory byte address
- mem_rd  out  1  memory read strobe, held until mem_ack
- mem_ack  in  1  one-cycle acknowledge; mem_din valid same cycle
- mem_din  in  8  memory read data
- busy  out  1  upload session in progress (selected index)
- done  out  1  one-cycle pulse when a selected session ends
- err  out  1  sticky: set on any timeout, cleared at the start of the next selected session

## Operation
- sel = ioctl_upload & (ioctl_index == INDEX). ioctl_rd ignored when sel low.
- States: IDLE, FETCH, DONE_WAIT.
- IDLE: ioctl_wait=0, mem_rd=0. On ioctl_rd & sel: latch ioctl_addr into mem_addr. If addr < SIZE -> FETCH with mem_rd=1, ioctl_wait=1, timeout counter cleared. Else ioctl_din<=8'hFF, stay IDLE, ioctl_wait never rises.
- FETCH: counter increments each cycle. mem_ack=1 -> ioctl_din<=mem_din, mem_rd<=0, ioctl_wait<=0, -> IDLE. Counter reaches TIMEOUT without ack -> ioctl_din<=8'hFF, err<=1, mem_rd<=0, ioctl_wait<=0, -> IDLE. ioctl_rd in FETCH is a protocol violation: ignored, no second fetch queued.
- Session tracking: busy follows sel registered (1-cycle delay). Falling edge of sel while busy -> done pulse for one cycle. Rising edge of sel clears err.
- sel dropping in FETCH -> DONE_WAIT: mem_rd held until mem_ack or timeout (memory transaction never abandoned mid-handshake), data discarded, ioctl_wait forced 0 immediately, then IDLE. No err on abort if ack arrives.
- Address compare is 25-bit unsigned; SIZE=0 makes every read return 8'hFF.

## Timing
- Reset values: ioctl_din=8'h00, ioctl_wait=0, mem_addr=0, mem_rd=0, busy=0, done=0, err=0, state IDLE, counter 0. Reset mid-FETCH drops mem_rd next edge; memory must tolerate an abandoned request.
- ioctl_rd at edge N: mem_rd and ioctl_wait high after edge N (visible cycle N+1).
- mem_ack at edge M: ioctl_din updated and ioctl_wait low after edge M; minimum request-to-data latency 2 cycles (mem_ack in the first FETCH cycle).
- Out-of-range read: ioctl_din=8'hFF after edge N, ioctl_wait stays 0.
- Timeout: ioctl_wait falls after exactly TIMEOUT+1 cycles in FETCH.
- mem_ack outside FETCH/DONE_WAIT ignored.

## Test plan
- Reset, then sel with INDEX=1, ioctl_rd addr 0x0010, mem_ack 3 cycles later with 8'hA5 -> mem_addr=0x0010, ioctl_wait high 3 cycles, ioctl_din=8'hA5, err=0.
- ioctl_rd addr 0x10000 (=SIZE) -> no mem_rd, ioctl_din=8'hFF next cycle, ioctl_wait stays 0.
- Never assert mem_ack, TIMEOUT=8 -> ioctl_wait drops after 9 FETCH cycles, ioctl_din=8'hFF, err=1; new session rising edge clears err.
- ioctl_index=2 with ioctl_rd -> no mem_rd, busy=0, no done on session end.
- Drop ioctl_upload during FETCH, ack 2 cycles later with 8'h3C -> ioctl_wait=0 immediately, mem_rd held until ack, ioctl_din unchanged, done pulses once.
- 256 back-to-back reads addr 0..255 with mem_ack immediate, mem_din=addr[7:0] -> each ioctl_din equals addr[7:0], done single pulse at end.
